// File: rtl/neuron_mac.sv
// Single-neuron MAC: bias + sum of N Q7.8 x*w products, rounded and saturated
// back to Q7.8 and presented to the sigmoid stage with a one-cycle strobe.
module neuron_mac #(
  parameter int unsigned N_INPUTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  input  logic [15:0] x_in,
  input  logic [15:0] w_in,
  output logic        busy,
  output logic [15:0] sig_in,
  output logic        sig_ena
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned CNT_W  = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_accept_start;
  logic                       w_beat;
  logic        [CNT_W-1:0]    r_cnt;
  logic signed [PROD_W-1:0]   r_prod_r;
  logic                       r_prod_v;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [PROD_W-1:0]   w_x;
  logic signed [PROD_W-1:0]   w_w;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_rnd;
  logic        [DATA_W-1:0]   w_sat;
  logic        [DATA_W-1:0]   r_sig_in;
  logic                       r_sig_ena;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and beat/start acceptance decode
  always_comb begin
    w_state_nxt    = r_state;
    w_accept_start = 1'b0;
    w_beat         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept_start = 1'b1;
          w_state_nxt    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          w_beat = 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands sign-extended to product width so the multiply is 32-bit signed
  assign w_x    = PROD_W'($signed(x_in));
  assign w_w    = PROD_W'($signed(w_in));
  assign w_prod = w_x * w_w;

  // Multiply stage and accumulator; the product lands in acc one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_prod_r <= '0;
      r_prod_v <= 1'b0;
    end else if (w_accept_start) begin
      r_acc    <= {{(ACC_W - DATA_W - FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
      r_cnt    <= '0;
      r_prod_v <= 1'b0;
    end else begin
      if (r_prod_v) begin
        r_acc <= r_acc + ACC_W'(r_prod_r);
      end
      r_prod_v <= w_beat;
      if (w_beat) begin
        r_prod_r <= w_prod;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Round half toward +inf, then saturate to Q7.8
  assign w_rnd = (r_acc + 40'sd128) >>> FRAC_W;

  always_comb begin
    w_sat = DATA_W'(w_rnd);
    if (w_rnd > 40'sd32767) begin
      w_sat = 16'h7FFF;
    end else if (w_rnd < -40'sd32768) begin
      w_sat = 16'h8000;
    end
  end

  // Result register and strobe toward the sigmoid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_in  <= '0;
      r_sig_ena <= 1'b0;
    end else begin
      r_sig_ena <= (r_state == S_OUT);
      if (r_state == S_OUT) begin
        r_sig_in <= w_sat;
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign sig_in  = r_sig_in;
  assign sig_ena = r_sig_ena;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: randomized neurons checked every cycle against an
// arithmetic model, plus hand-computed results for the directed cases.
module tb_neuron_mac;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic        busy;
  logic [15:0] sig_in;
  logic        sig_ena;

  neuron_mac #(.N_INPUTS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .x_in     (x_in),
    .w_in     (w_in),
    .busy     (busy),
    .sig_in   (sig_in),
    .sig_ena  (sig_ena)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: a neuron is a running sum; N beats later plus two edges the
  // rounded, clamped sum appears with a strobe
  bit     m_busy = 1'b0;
  bit     m_ena  = 1'b0;
  longint m_sig  = 0;
  longint m_sum  = 0;
  int     m_cnt  = 0;
  int     m_tail = 0;

  function automatic longint q78_result(input longint sum);
    longint r;
    r = (sum + 128) >>> 8;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_ena = 1'b0; m_sig = 0; m_sum = 0; m_cnt = 0; m_tail = 0;
    end else begin
      m_ena = 1'b0;
      if (m_tail > 0) begin
        m_tail--;
        if (m_tail == 0) begin
          m_sig  = q78_result(m_sum);
          m_ena  = 1'b1;
          m_busy = 1'b0;
        end
      end else if (!m_busy && start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_sum  = longint'($signed(bias)) * 256;
      end else if (m_busy && in_valid) begin
        m_sum += longint'($signed(x_in)) * longint'($signed(w_in));
        m_cnt++;
        if (m_cnt == N) m_tail = 2;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", longint'(busy), longint'(m_busy));
      check("sig_ena", longint'(sig_ena), longint'(m_ena));
      check("sig_in", longint'($signed(sig_in)), m_sig);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_noise(input int n);
    repeat (n) begin
      in_valid = 1'($urandom_range(0, 1));
      x_in     = 16'($urandom);
      w_in     = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // One full neuron; returns the strobed result and the cycle it was seen
  task automatic run(input logic [15:0] b, input logic [15:0] xs[N], input logic [15:0] ws[N],
                     input int min_gap, input int max_gap, input bit noise,
                     output logic [15:0] res, output int strobe_cyc);
    int gap;
    bit found;
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    bias  = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      gap = $urandom_range(min_gap, max_gap);
      repeat (gap) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid = 1'b1;
      x_in     = xs[i];
      w_in     = ws[i];
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
    end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      x_in     = 16'($urandom);
      w_in     = 16'($urandom);
      tick();
      in_valid = 1'b0;
      if (sig_ena) begin
        check("strobe_latency", k + 1, 2);
        found = 1'b1;
        break;
      end
    end
    if (!found) check("strobe_timeout", 0, 1);
    res        = sig_in;
    strobe_cyc = cyc;
  endtask

  logic [15:0] xs [N];
  logic [15:0] ws [N];
  logic [15:0] r0, r1, r2;
  int          c0, c1;

  initial begin
    rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0; x_in = '0; w_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    check("reset_busy", longint'(busy), 0);
    check("reset_sig_in", longint'(sig_in), 0);
    rst_n = 1'b1;
    idle_noise(3);

    // Basic dot product: 4 x (1.0 * 0.5) = 2.0
    xs = '{16'd256, 16'd256, 16'd256, 16'd256};
    ws = '{16'd128, 16'd128, 16'd128, 16'd128};
    run(16'd0, xs, ws, 0, 0, 1'b0, r0, c0);
    check("basic_dot", longint'($signed(r0)), 512);
    check("basic_busy_fall", longint'(busy), 0);
    tick();
    check("basic_ena_single", longint'(sig_ena), 0);

    // Rounding half toward +inf
    xs = '{16'd1, 16'd0, 16'd0, 16'd0};
    ws = '{16'd128, 16'd0, 16'd0, 16'd0};
    run(16'd0, xs, ws, 0, 0, 1'b0, r0, c0);
    check("round_pos", longint'($signed(r0)), 1);
    check("model_round_pos", m_sig, 1);
    xs[0] = 16'hFFFF;
    run(16'd0, xs, ws, 0, 0, 1'b0, r0, c0);
    check("round_neg", longint'($signed(r0)), 0);

    // Saturation and bias
    xs = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    ws = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run(16'd0, xs, ws, 0, 0, 1'b0, r0, c0);
    check("sat_pos", longint'($signed(r0)), 32767);
    ws = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run(16'd0, xs, ws, 0, 0, 1'b0, r0, c0);
    check("sat_neg", longint'($signed(r0)), -32768);
    check("model_sat_neg", m_sig, -32768);
    xs = '{16'd0, 16'd0, 16'd0, 16'd0};
    run(16'hFF00, xs, xs, 0, 0, 1'b0, r0, c0);
    check("bias_only", longint'($signed(r0)), -256);
    check("model_bias_only", m_sig, -256);

    // Gaps and ignored inputs give the same result as back-to-back beats
    for (int i = 0; i < N; i++) begin
      xs[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
      ws[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
    end
    run(16'h0080, xs, ws, 0, 0, 1'b0, r0, c0);
    idle_noise(4);
    run(16'h0080, xs, ws, 1, 3, 1'b0, r1, c0);
    check("gap_equal", longint'(r1), longint'(r0));
    idle_noise(4);
    run(16'h0080, xs, ws, 1, 3, 1'b1, r2, c0);
    check("noise_equal", longint'(r2), longint'(r0));

    // Reset after two beats discards the partial neuron
    start = 1'b1; bias = 16'h0100; tick(); start = 1'b0;
    xs = '{16'd256, 16'd256, 16'd256, 16'd256};
    ws = '{16'd128, 16'd128, 16'd128, 16'd128};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x_in = 16'd1000; w_in = 16'd1000; tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_sig_in", longint'(sig_in), 0);
    tick();
    tick();
    rst_n = 1'b1;
    idle_noise(2);
    run(16'd0, xs, ws, 0, 2, 1'b0, r0, c0);
    check("after_reset", longint'($signed(r0)), 512);

    // Back-to-back neurons: strobes N+3 cycles apart
    ws = '{16'd256, 16'd256, 16'd256, 16'd256};
    run(16'd0, xs, ws, 0, 0, 1'b0, r0, c0);
    run(16'hFF00, xs, xs, 0, 0, 1'b0, r1, c1);
    check("b2b_first", longint'($signed(r0)), 1024);
    check("b2b_second", longint'($signed(r1)), 768);
    check("b2b_period", c1 - c0, N + 3);

    // Randomized neurons against the model
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        if (t % 3 == 0) begin
          xs[i] = 16'($urandom);
          ws[i] = 16'($urandom);
        end else begin
          xs[i] = 16'($urandom_range(0, 1023)) - 16'd512;
          ws[i] = 16'($urandom_range(0, 1023)) - 16'd512;
        end
      end
      run(16'($urandom), xs, ws, 0, 3, 1'($urandom_range(0, 1)), r0, c0);
      if ($urandom_range(0, 2) != 0) idle_noise($urandom_range(1, 3));
    end

    idle_noise(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
